// File: rtl/wrr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wrr_pkg
// Purpose  : Shared constants and types for the weighted-round-robin VC path.
//            NUM_VC        - number of virtual channels
//            vc_id_t       - virtual-channel index type
//            DEFAULT_DEPTH - default per-VC FIFO depth
// Revision : 1.0 - initial release
// ============================================================================
package wrr_pkg;

  localparam int NUM_VC        = 4;
  localparam int DEFAULT_DEPTH = 8;

  typedef logic [1:0] vc_id_t;

endpackage
`default_nettype wire

// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo
// Purpose  : Single 1-bit-wide circular FIFO for one virtual channel.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-low
//            push       - write strobe
//            push_data  - write data bit
//            pop        - read strobe
//            empty/full - occupancy status (state derived, no extra latency)
//            count      - current occupancy, 0..DEPTH
//            head       - entry at the read pointer, 0 while empty
//            ovf_evt    - push rejected because FIFO full (this cycle)
//            unf_evt    - pop rejected because FIFO empty (this cycle)
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo
  import wrr_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          head,
  output logic          ovf_evt,
  output logic          unf_evt
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_pop_ok  = pop && !w_empty;
  // A pop draining a full FIFO frees a slot in the same cycle.
  assign w_push_ok = push && (!w_full || w_pop_ok);

  assign ovf_evt = push && !w_push_ok;
  assign unf_evt = pop && w_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;
  assign head  = w_empty ? 1'b0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_bank
// Purpose  : Bank of NUM_VC 1-bit virtual-channel FIFOs with one shared
//            read port selected by the downstream arbiter grant.
// Ports    : clk         - clock, rising edge
//            reset       - synchronous, active-low
//            push_en     - per-VC write strobes
//            push_data   - per-VC write data bits
//            pop_en      - read strobe (arbiter grant valid)
//            pop_vc      - VC being read (arbiter grant id)
//            Data_Word   - head bit of each VC, 0 while that VC is empty
//            fifo_empty  - per-VC empty
//            fifo_full   - per-VC full
//            almost_full - per-VC occupancy >= AF_THR
//            ovf_err     - sticky overflow flag
//            unf_err     - sticky underflow flag
// Config   : VC_FIFO_ALMOST_FULL_EN - enables the almost_full comparators;
//            when undefined almost_full is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo_bank
  import wrr_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AF_THR = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_VC-1:0] push_en,
  input  logic [NUM_VC-1:0] push_data,
  input  logic              pop_en,
  input  vc_id_t            pop_vc,
  output logic [NUM_VC-1:0] Data_Word,
  output logic [NUM_VC-1:0] fifo_empty,
  output logic [NUM_VC-1:0] fifo_full,
  output logic [NUM_VC-1:0] almost_full,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_VC-1:0]         w_pop;
  logic [NUM_VC-1:0]         w_ovf;
  logic [NUM_VC-1:0]         w_unf;
  logic [NUM_VC-1:0][CW-1:0] w_count;

  logic r_ovf_err;
  logic r_unf_err;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign w_pop[i] = pop_en && (pop_vc == vc_id_t'(i));

    vc_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en[i]),
      .push_data (push_data[i]),
      .pop       (w_pop[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i]),
      .count     (w_count[i]),
      .head      (Data_Word[i]),
      .ovf_evt   (w_ovf[i]),
      .unf_evt   (w_unf[i])
    );

`ifdef VC_FIFO_ALMOST_FULL_EN
    assign almost_full[i] = (w_count[i] >= CW'(AF_THR));
`endif
  end

`ifndef VC_FIFO_ALMOST_FULL_EN
  // Occupancy has no consumer in this build.
  logic w_unused_count;
  assign w_unused_count = ^w_count;
  assign almost_full    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (|w_ovf) r_ovf_err <= 1'b1;
      if (|w_unf) r_unf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_fifo_bank
// Purpose  : Self-checking bench for vc_fifo_bank against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_fifo_bank;

  localparam int DEPTH  = 8;
  localparam int AF_THR = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] push_en;
  logic [3:0] push_data;
  logic       pop_en;
  logic [1:0] pop_vc;
  wire  [3:0] Data_Word;
  wire  [3:0] fifo_empty;
  wire  [3:0] fifo_full;
  wire  [3:0] almost_full;
  wire        ovf_err;
  wire        unf_err;

  vc_fifo_bank #(.DEPTH(DEPTH), .AF_THR(AF_THR)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_en     (push_en),
    .push_data   (push_data),
    .pop_en      (pop_en),
    .pop_vc      (pop_vc),
    .Data_Word   (Data_Word),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per VC plus sticky error bits.
  bit mq[4][$];
  bit m_ovf;
  bit m_unf;
  int tests;
  int fails;

  function automatic logic [3:0] exp_empty();
    for (int i = 0; i < 4; i++) exp_empty[i] = (mq[i].size() == 0);
  endfunction

  function automatic logic [3:0] exp_full();
    for (int i = 0; i < 4; i++) exp_full[i] = (mq[i].size() == DEPTH);
  endfunction

  function automatic logic [3:0] exp_head();
    for (int i = 0; i < 4; i++) exp_head[i] = (mq[i].size() > 0) ? mq[i][0] : 1'b0;
  endfunction

  function automatic logic [3:0] exp_af();
    exp_af = 4'b0000;
`ifdef VC_FIFO_ALMOST_FULL_EN
    for (int i = 0; i < 4; i++) exp_af[i] = (mq[i].size() >= AF_THR);
`endif
  endfunction

  // Update the model from the current inputs, then advance one clock.
  task automatic tick();
    bit pop_ok [4];
    bit push_ok[4];
    if (!reset) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pop_ok[i] = pop_en && (int'(pop_vc) == i) && (mq[i].size() > 0);
        if (pop_en && (int'(pop_vc) == i) && (mq[i].size() == 0)) m_unf = 1'b1;
        push_ok[i] = push_en[i] && ((mq[i].size() < DEPTH) || pop_ok[i]);
        if (push_en[i] && !push_ok[i]) m_ovf = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (pop_ok[i])  void'(mq[i].pop_front());
        if (push_ok[i]) mq[i].push_back(push_data[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_en   = 4'b0;
    push_data = 4'b0;
    pop_en    = 1'b0;
    pop_vc    = 2'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    push_en   = 4'hF;
    push_data = 4'hF;
    pop_en    = 1'b1;
    pop_vc    = 2'd1;
    tick();
    tick();
    tests++; if (fifo_empty !== 4'b1111) begin fails++; $display("FAIL reset_empty got=%b exp=%b", fifo_empty, 4'b1111); end
    tests++; if (fifo_full !== 4'b0000) begin fails++; $display("FAIL reset_full got=%b exp=%b", fifo_full, 4'b0000); end
    tests++; if (Data_Word !== 4'b0000) begin fails++; $display("FAIL reset_data got=%b exp=%b", Data_Word, 4'b0000); end
    tests++; if (almost_full !== 4'b0000) begin fails++; $display("FAIL reset_af got=%b exp=%b", almost_full, 4'b0000); end
    tests++; if ({ovf_err, unf_err} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b exp=00", {ovf_err, unf_err}); end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_wrap();
    bit seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        idle();
        push_en[2]   = 1'b1;
        push_data[2] = seq[k];
        tick();
      end
      for (int k = 0; k < 8; k++) begin
        idle();
        tests++; if (Data_Word[2] !== seq[k]) begin fails++; $display("FAIL wrap_head r=%0d k=%0d got=%b exp=%b", r, k, Data_Word[2], seq[k]); end
        pop_en = 1'b1;
        pop_vc = 2'd2;
        tick();
      end
      idle();
      tests++; if (fifo_empty[2] !== 1'b1) begin fails++; $display("FAIL wrap_empty r=%0d got=%b exp=1", r, fifo_empty[2]); end
    end
    tests++; if (unf_err !== 1'b0) begin fails++; $display("FAIL wrap_unf got=%b exp=0", unf_err); end
  endtask

  task automatic test_full();
    bit bits[9];
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bits[k] = 1'($urandom);
      idle();
      push_en[0]   = 1'b1;
      push_data[0] = bits[k];
      tick();
      if (k == 6) begin
        tests++; if (fifo_full[0] !== 1'b0) begin fails++; $display("FAIL full_early got=%b exp=0", fifo_full[0]); end
      end
      if (k == 7) begin
        tests++; if (fifo_full[0] !== 1'b1) begin fails++; $display("FAIL full_after8 got=%b exp=1", fifo_full[0]); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL full_ovf_early got=%b exp=0", ovf_err); end
      end
    end
    idle();
    tests++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL full_ovf got=%b exp=1", ovf_err); end
    tests++; if (Data_Word[0] !== bits[0]) begin fails++; $display("FAIL full_head got=%b exp=%b", Data_Word[0], bits[0]); end
    pop_en = 1'b1;
    pop_vc = 2'd0;
    tick();
    idle();
    tests++; if (Data_Word[0] !== bits[1]) begin fails++; $display("FAIL full_pop_head got=%b exp=%b", Data_Word[0], bits[1]); end
    tests++; if (fifo_full[0] !== 1'b0) begin fails++; $display("FAIL full_after_pop got=%b exp=0", fifo_full[0]); end
  endtask

  task automatic test_simultaneous();
    bit bits[8];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bits[k] = (k == 0) ? 1'b1 : ((k == 1) ? 1'b0 : 1'($urandom));
      idle();
      push_en[1]   = 1'b1;
      push_data[1] = bits[k];
      tick();
    end
    idle();
    push_en[1]   = 1'b1;
    push_data[1] = 1'b1;
    pop_en       = 1'b1;
    pop_vc       = 2'd1;
    tick();
    idle();
    tests++; if (fifo_full[1] !== 1'b1) begin fails++; $display("FAIL simul_full got=%b exp=1", fifo_full[1]); end
    tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL simul_ovf got=%b exp=0", ovf_err); end
    tests++; if (Data_Word[1] !== bits[1]) begin fails++; $display("FAIL simul_head got=%b exp=%b", Data_Word[1], bits[1]); end
  endtask

  task automatic test_underflow();
    do_reset();
    push_en[3]   = 1'b1;
    push_data[3] = 1'b1;
    pop_en       = 1'b1;
    pop_vc       = 2'd3;
    tick();
    idle();
    tests++; if (unf_err !== 1'b1) begin fails++; $display("FAIL unf_flag got=%b exp=1", unf_err); end
    tests++; if (Data_Word[3] !== 1'b1) begin fails++; $display("FAIL unf_head got=%b exp=1", Data_Word[3]); end
    tests++; if (fifo_empty[3] !== 1'b0) begin fails++; $display("FAIL unf_empty got=%b exp=0", fifo_empty[3]); end
    tick();
    tests++; if (unf_err !== 1'b1) begin fails++; $display("FAIL unf_sticky got=%b exp=1", unf_err); end
  endtask

  task automatic test_almost_full();
    bit exp_on;
`ifdef VC_FIFO_ALMOST_FULL_EN
    exp_on = 1'b1;
`else
    exp_on = 1'b0;
`endif
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle();
      push_en[0]   = 1'b1;
      push_data[0] = 1'($urandom);
      tick();
      if (k == 4) begin
        tests++; if (almost_full[0] !== 1'b0) begin fails++; $display("FAIL af_at5 got=%b exp=0", almost_full[0]); end
      end
    end
    idle();
    tests++; if (almost_full[0] !== exp_on) begin fails++; $display("FAIL af_at6 got=%b exp=%b", almost_full[0], exp_on); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(59) != 0);
      push_en   = 4'($urandom);
      push_data = 4'($urandom);
      pop_en    = ($urandom_range(9) < 6);
      pop_vc    = 2'($urandom_range(3));
      tick();
      tests++; if (fifo_empty !== exp_empty()) begin fails++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, fifo_empty, exp_empty()); end
      tests++; if (fifo_full !== exp_full()) begin fails++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, fifo_full, exp_full()); end
      tests++; if (Data_Word !== exp_head()) begin fails++; $display("FAIL rnd_data n=%0d got=%b exp=%b", n, Data_Word, exp_head()); end
      tests++; if (almost_full !== exp_af()) begin fails++; $display("FAIL rnd_af n=%0d got=%b exp=%b", n, almost_full, exp_af()); end
      tests++; if ({ovf_err, unf_err} !== {m_ovf, m_unf}) begin fails++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, {ovf_err, unf_err}, {m_ovf, m_unf}); end
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    reset = 1'b0;
    test_reset();
    test_wrap();
    test_full();
    test_simultaneous();
    test_underflow();
    test_almost_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vc_fifo_bank.md
VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving entries per virtual-channel FIFO (power of two, 2..16).
REQ-002 The block SHALL have parameter AF_THR, default 6, giving the almost-full occupancy threshold (1..DEPTH-1).
REQ-003 The block SHALL have port clk  input  1  the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port push_en  input  4  per-VC write strobes, with bit i for VC i.
REQ-006 The block SHALL have port push_data  input  4  per-VC write data bits, with bit i for VC i.
REQ-007 The block SHALL have port pop_en  input  1  the read strobe driven by the downstream arbiter grant.
REQ-008 The block SHALL have port pop_vc  input  2  the VC being read, equal to the wrr grant_id.
REQ-009 The block SHALL have port Data_Word  output  4  the head bit of each VC FIFO, feeding mux4_1.
REQ-010 The block SHALL have ports fifo_empty and fifo_full  output  4 each  per-VC status.
REQ-011 The block SHALL have port almost_full  output  4  per-VC occupancy >= AF_THR.
REQ-012 The block SHALL have port ovf_err and unf_err  output  1 each  sticky overflow and underflow flags.

Function
REQ-013 Each VC SHALL hold a circular buffer with a write pointer, a read pointer and a count of width $clog2(DEPTH)+1.
REQ-014 Both pointers SHALL wrap modulo DEPTH, from DEPTH-1 to 0.
REQ-015 Data_Word[i] SHALL be combinational from VC i's read-pointer entry, and 0 while VC i is empty.
REQ-016 A push to VC i SHALL be accepted when push_en[i]=1 and VC i is not full; data SHALL be visible at head one cycle later if VC i was empty.
REQ-017 A pop SHALL be accepted when pop_en=1 and VC pop_vc is not empty; the read pointer SHALL advance and count SHALL decrement at the next edge.
REQ-018 A simultaneous push and pop on the same full VC SHALL both be accepted; count SHALL stay DEPTH and no overflow SHALL be flagged.
REQ-019 A simultaneous push and pop on the same empty VC SHALL accept the push, reject the pop, and set unf_err.
REQ-020 A push to a full VC without a same-VC pop SHALL be dropped and SHALL set ovf_err.
REQ-021 Pushes to several VCs and one pop on any VC in the same cycle SHALL all be processed independently.
REQ-022 fifo_empty[i] SHALL be (count==0), fifo_full[i] SHALL be (count==DEPTH), and both SHALL be registered-state derived with no extra latency.
REQ-023 ovf_err and unf_err SHALL stay 1 once set, until reset.

Reset
REQ-024 While reset=0 at a clock edge, all pointers and counts SHALL clear, and fifo_empty SHALL be 4'b1111, fifo_full 0, almost_full 0, ovf_err 0, unf_err 0 and Data_Word 0.
REQ-025 Reset asserted mid-operation SHALL discard all stored data, and push or pop in that cycle SHALL be ignored.
REQ-026 Storage array contents SHALL need no reset.

Configuration
REQ-027 With VC_FIFO_ALMOST_FULL_EN defined, almost_full[i] SHALL be 1 when count >= AF_THR.
REQ-028 Without VC_FIFO_ALMOST_FULL_EN, the almost_full port SHALL remain present and SHALL be tied to 4'b0000, with no comparator logic.

Structure
REQ-029 The shared package wrr_pkg SHALL hold NUM_VC=4, the vc_id_t 2-bit type and the default DEPTH constant.
REQ-030 The per-VC FIFO SHALL be a sub-module vc_fifo (1-bit wide, DEPTH deep, with push/pop/empty/full/count/head ports) instantiated NUM_VC times.
REQ-031 vc_fifo_bank SHALL decode pop_vc into per-VC pop strobes and OR the error flags together.

Verification
REQ-032 Reset test: hold reset=0 for 2 cycles -> fifo_empty=4'b1111, Data_Word=0 and both error flags 0.
REQ-033 Wrap test: push VC2 data 1,0,1,1,0,0,1,0 then 8 pops on VC2 -> Data_Word[2] sequence 1,0,1,1,0,0,1,0; repeat once -> identical after pointer wrap, and fifo_empty[2]=1 at end.
REQ-034 Full test: push 9 bits into VC0 -> fifo_full[0]=1 after the 8th push, ovf_err=1 after the 9th, and a pop returns the first bit.
REQ-035 Simultaneous test: with VC1 full, push and pop VC1 in one cycle -> count stays 8, ovf_err=0, and head advances to the 2nd bit.
REQ-036 Underflow test: pop VC3 while empty with push_en[3]=1 and push_data[3]=1 -> unf_err=1 and Data_Word[3]=1 next cycle.
REQ-037 Almost-full test: push 6 bits into VC0 -> almost_full[0]=1 with VC_FIFO_ALMOST_FULL_EN defined, and stays 0 without it.
